// File: rtl/lvds_tx_if.sv
// lvds_tx_if: FIFO read side and DDR output side of the LVDS I/Q serializer
interface lvds_tx_if;
  logic        i_enable;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_data;
  logic        o_fifo_read_clk;
  logic        o_fifo_pull;
  logic [1:0]  o_ddr_data;
  logic        o_busy;
  logic        o_underrun;
  modport master(output i_enable, i_fifo_empty, i_fifo_data,
                 input o_fifo_read_clk, o_fifo_pull, o_ddr_data, o_busy, o_underrun);
  modport slave(input i_enable, i_fifo_empty, i_fifo_data,
                output o_fifo_read_clk, o_fifo_pull, o_ddr_data, o_busy, o_underrun);
endinterface

// File: rtl/lvds_tx.sv
// lvds_tx: pops 32-bit I/Q words from the TX FIFO and sends each as 16 dibits, MSB first
module lvds_tx #(
  parameter bit         FORCE_SYNC = 1'b1,
  parameter logic [1:0] IDLE_DIBIT = 2'b00
) (
  input logic       i_ddr_clk,
  input logic       i_reset,
  lvds_tx_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TX} state_e;
  state_e      state_q, state_d;
  logic [3:0]  n_q, n_d;
  logic [31:0] sr_q, sr_d, word;
  logic [1:0]  ddr_q, ddr_d;
  logic        pend_q, und_q, und_d, pull, load;
  assign word = FORCE_SYNC ? {2'b10, bus.i_fifo_data[29:16], 2'b01, bus.i_fifo_data[13:0]}
                           : bus.i_fifo_data;
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      sr_q    <= '0;
      ddr_q   <= IDLE_DIBIT;
      pend_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      sr_q    <= sr_d;
      ddr_q   <= ddr_d;
      pend_q  <= pull;
      und_q   <= und_d;
    end
  end
  // A popped word loads either after ST_WAIT or on the last dibit of a frame, keeping frames gapless
  always_comb begin
    load    = state_q == ST_WAIT || (state_q == ST_TX && n_q == 4'd15 && pend_q);
    state_d = load ? ST_TX
            : state_q == ST_IDLE ? (pull ? ST_WAIT : ST_IDLE)
            : (state_q == ST_TX && n_q != 4'd15) ? ST_TX : ST_IDLE;
    n_d     = load ? 4'd0 : state_q == ST_TX ? n_q + 4'd1 : n_q;
    sr_d    = load ? word : sr_q << 2;
    ddr_d   = state_d == ST_TX ? sr_d[31:30] : IDLE_DIBIT;
  end
  always_comb begin
    pull  = !i_reset && bus.i_enable && !bus.i_fifo_empty
            && (state_q == ST_IDLE || (state_q == ST_TX && n_q == 4'd14));
    und_d = state_q == ST_TX && n_q == 4'd14 && bus.i_enable && bus.i_fifo_empty;
  end
  assign bus.o_fifo_read_clk = i_ddr_clk;
  assign bus.o_fifo_pull     = pull;
  assign bus.o_ddr_data      = ddr_q;
  assign bus.o_busy          = state_q != ST_IDLE;
  assign bus.o_underrun      = und_q;
endmodule
